// File: rtl/instruction_encoder_if.sv
// Field-bundle handshake and instruction-memory write bus for instruction_encoder.
// The master side drives the decoded fields; the slave side is the encoder.
interface instruction_encoder_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  enc_valid;
  logic                  enc_ready;
  logic [1:0]            fmt;
  logic [4:0]            rd;
  logic [4:0]            rs1;
  logic [4:0]            rs2;
  logic [2:0]            funct3;
  logic [31:0]           imm;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;
  logic [ADDR_WIDTH:0]   count;
  logic                  full;
  logic                  err_pulse;
  logic [7:0]            err_count;

  modport master (
    output enc_valid, fmt, rd, rs1, rs2, funct3, imm,
    input  enc_ready, imem_we, imem_addr, imem_wdata, count, full, err_pulse, err_count
  );

  modport slave (
    input  enc_valid, fmt, rd, rs1, rs2, funct3, imm,
    output enc_ready, imem_we, imem_addr, imem_wdata, count, full, err_pulse, err_count
  );
endinterface

// File: rtl/instruction_encoder.sv
// Packs decoded RV32I fields (I, S, SB layouts) into machine words, range-checks
// the immediate and writes legal words sequentially into instruction memory.
module instruction_encoder #(
  parameter int ADDR_WIDTH = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  input logic                 clear,
  instruction_encoder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ENC, WRITE} state_t;

  localparam logic [ADDR_WIDTH:0] DepthCount = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                state_q;
  logic [1:0]            fmt_q;
  logic [4:0]            rd_q;
  logic [4:0]            rs1_q;
  logic [4:0]            rs2_q;
  logic [2:0]            funct3_q;
  logic [31:0]           imm_q;
  logic                  imemWe_q;
  logic [ADDR_WIDTH-1:0] imemAddr_q;
  logic [31:0]           imemWdata_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  full_q;
  logic                  errPulse_q;
  logic [7:0]            errCount_q;

  logic [6:0]            opcode_d;
  logic [31:0]           word_d;
  logic                  legal_d;
  logic                  fits12_d;
  logic                  fits13Even_d;
  logic [ADDR_WIDTH:0]   countInc_d;

  // A value fits a signed N-bit field when every bit above N-1 equals the sign bit.
  always_comb begin
    opcode_d     = 7'b0000011;
    word_d       = '0;
    legal_d      = 1'b0;
    fits12_d     = (&imm_q[31:11]) || (~|imm_q[31:11]);
    fits13Even_d = ((&imm_q[31:12]) || (~|imm_q[31:12])) && !imm_q[0];
    countInc_d   = count_q + 1'b1;
    case (fmt_q)
      2'b00:   opcode_d = 7'b0000011;
      2'b01:   opcode_d = 7'b0010011;
      2'b10:   opcode_d = 7'b0100011;
      default: opcode_d = 7'b1100011;
    endcase
    case (fmt_q)
      2'b10: begin
        word_d  = {imm_q[11:5], rs2_q, rs1_q, funct3_q, imm_q[4:0], opcode_d};
        legal_d = fits12_d;
      end
      2'b11: begin
        word_d  = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, funct3_q, imm_q[4:1], imm_q[11], opcode_d};
        legal_d = fits13Even_d;
      end
      default: begin
        word_d  = {imm_q[11:0], rs1_q, funct3_q, rd_q, opcode_d};
        legal_d = fits12_d;
      end
    endcase
  end

  // clear overrides every transition; a captured but unwritten bundle is simply dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fmt_q       <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      funct3_q    <= '0;
      imm_q       <= '0;
      imemWe_q    <= 1'b0;
      imemAddr_q  <= '0;
      imemWdata_q <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      errPulse_q  <= 1'b0;
      errCount_q  <= '0;
    end else begin
      errPulse_q <= 1'b0;
      if (clear) begin
        state_q    <= IDLE;
        imemWe_q   <= 1'b0;
        count_q    <= '0;
        full_q     <= 1'b0;
        errCount_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.enc_valid && !full_q) begin
              fmt_q    <= bus.fmt;
              rd_q     <= bus.rd;
              rs1_q    <= bus.rs1;
              rs2_q    <= bus.rs2;
              funct3_q <= bus.funct3;
              imm_q    <= bus.imm;
              state_q  <= ENC;
            end
          end
          ENC: begin
            if (legal_d) begin
              imemWe_q    <= 1'b1;
              imemAddr_q  <= count_q[ADDR_WIDTH-1:0];
              imemWdata_q <= word_d;
              state_q     <= WRITE;
            end else begin
              errPulse_q <= 1'b1;
              if (errCount_q != 8'hFF) begin
                errCount_q <= errCount_q + 8'd1;
              end
              state_q <= IDLE;
            end
          end
          WRITE: begin
            imemWe_q <= 1'b0;
            count_q  <= countInc_d;
            full_q   <= (countInc_d == DepthCount);
            state_q  <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.enc_ready  = (state_q == IDLE) && !full_q;
  assign bus.imem_we    = imemWe_q;
  assign bus.imem_addr  = imemAddr_q;
  assign bus.imem_wdata = imemWdata_q;
  assign bus.count      = count_q;
  assign bus.full       = full_q;
  assign bus.err_pulse  = errPulse_q;
  assign bus.err_count  = errCount_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder with a 4-word memory so the full
// condition is reachable; expected words are hand-encoded constants.
module tb_instruction_encoder;

  localparam int AW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;

  int checks = 0;
  int failures = 0;

  int wrCount = 0;
  int errPulses = 0;
  logic [AW-1:0] wrAddr[$];
  logic [31:0]   wrData[$];

  instruction_encoder_if #(.ADDR_WIDTH(AW)) bus ();

  instruction_encoder #(.ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Log every write strobe and error strobe seen mid-cycle.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      wrAddr.push_back(bus.imem_addr);
      wrData.push_back(bus.imem_wdata);
      wrCount++;
    end
    if (bus.err_pulse === 1'b1) errPulses++;
  end

  task automatic issue(input logic [1:0] f, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [2:0] f3, input logic [31:0] im);
    bit accepted = 0;
    @(negedge clk);
    bus.fmt = f; bus.rd = d; bus.rs1 = s1; bus.rs2 = s2; bus.funct3 = f3; bus.imm = im;
    bus.enc_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus.enc_ready === 1'b1) begin
        accepted = 1;
        break;
      end
      @(negedge clk);
    end
    if (accepted) @(posedge clk);
    #1;
    bus.enc_valid = 1'b0;
    if (!accepted) begin
      checks++; failures++;
      $display("[TB] FAIL issue_timeout: enc_ready never high, required within 20 cycles");
    end
  endtask

  task automatic pulseClear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (bus.imem_we !== 1'b0 || bus.imem_addr !== 2'd0 || bus.imem_wdata !== 32'd0) begin
      failures++; $display("[TB] FAIL reset_write_port: we=%b addr=%0d data=%h required 0/0/0", bus.imem_we, bus.imem_addr, bus.imem_wdata); end
    checks++; if (bus.count !== 3'd0 || bus.full !== 1'b0 || bus.err_pulse !== 1'b0 || bus.err_count !== 8'd0) begin
      failures++; $display("[TB] FAIL reset_status: count=%0d full=%b err=%b errcnt=%0d required all 0", bus.count, bus.full, bus.err_pulse, bus.err_count); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (bus.enc_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL reset_ready: enc_ready=%b required 1", bus.enc_ready); end
  endtask

  task automatic test_i_alu();
    int base = wrCount;
    issue(2'b01, 5'd5, 5'd6, 5'd0, 3'd0, 32'hFFFFFFFF);
    @(negedge clk);
    checks++; if (bus.imem_we !== 1'b0 || bus.enc_ready !== 1'b0) begin
      failures++; $display("[TB] FAIL i_enc_cycle: we=%b ready=%b required 0/0", bus.imem_we, bus.enc_ready); end
    @(negedge clk);
    checks++; if (bus.imem_we !== 1'b1 || bus.imem_addr !== 2'd0 || bus.imem_wdata !== 32'hFFF30293) begin
      failures++; $display("[TB] FAIL i_write_cycle: we=%b addr=%0d data=%h required 1/0/fff30293", bus.imem_we, bus.imem_addr, bus.imem_wdata); end
    @(negedge clk);
    checks++; if (bus.imem_we !== 1'b0 || bus.count !== 3'd1 || bus.enc_ready !== 1'b1 || bus.imem_wdata !== 32'hFFF30293) begin
      failures++; $display("[TB] FAIL i_after_write: we=%b count=%0d ready=%b data=%h required 0/1/1/fff30293", bus.imem_we, bus.count, bus.enc_ready, bus.imem_wdata); end
    checks++; if (wrCount - base !== 1) begin
      failures++; $display("[TB] FAIL i_write_count: got %0d strobes required 1", wrCount - base); end
  endtask

  task automatic test_s_sb();
    int base = wrCount;
    issue(2'b10, 5'd0, 5'd2, 5'd7, 3'd2, 32'd8);
    repeat (3) @(negedge clk);
    issue(2'b11, 5'd0, 5'd1, 5'd2, 3'd0, 32'hFFFFFFFC);
    repeat (3) @(negedge clk);
    checks++; if (wrCount - base !== 2) begin
      failures++; $display("[TB] FAIL s_sb_strobes: got %0d required 2", wrCount - base); end
    else begin
      checks++; if (wrAddr[base] !== 2'd1 || wrData[base] !== 32'h00712423) begin
        failures++; $display("[TB] FAIL s_word: addr=%0d data=%h required 1/00712423", wrAddr[base], wrData[base]); end
      checks++; if (wrAddr[base+1] !== 2'd2 || wrData[base+1] !== 32'hFE208EE3) begin
        failures++; $display("[TB] FAIL sb_word: addr=%0d data=%h required 2/fe208ee3", wrAddr[base+1], wrData[base+1]); end
    end
    checks++; if (bus.count !== 3'd3) begin
      failures++; $display("[TB] FAIL s_sb_count: got %0d required 3", bus.count); end
  endtask

  task automatic test_errors();
    int base = wrCount;
    int errBase = errPulses;
    issue(2'b00, 5'd1, 5'd0, 5'd0, 3'd2, 32'd2048);
    @(negedge clk);
    checks++; if (bus.err_pulse !== 1'b0) begin
      failures++; $display("[TB] FAIL err_early: err_pulse=%b required 0 in encode cycle", bus.err_pulse); end
    @(negedge clk);
    checks++; if (bus.err_pulse !== 1'b1 || bus.enc_ready !== 1'b1 || bus.imem_we !== 1'b0) begin
      failures++; $display("[TB] FAIL err_strobe: err=%b ready=%b we=%b required 1/1/0", bus.err_pulse, bus.enc_ready, bus.imem_we); end
    issue(2'b11, 5'd0, 5'd1, 5'd2, 3'd0, 32'd5);
    repeat (3) @(negedge clk);
    checks++; if (errPulses - errBase !== 2 || bus.err_count !== 8'd2 || wrCount !== base || bus.count !== 3'd3) begin
      failures++; $display("[TB] FAIL err_totals: pulses=%0d errcnt=%0d writes=%0d count=%0d required 2/2/0/3", errPulses - errBase, bus.err_count, wrCount - base, bus.count); end
    issue(2'b00, 5'd1, 5'd0, 5'd0, 3'd2, 32'hFFFFF800);
    repeat (3) @(negedge clk);
    checks++; if (wrCount - base !== 1 || bus.imem_addr !== 2'd3 || bus.imem_wdata !== 32'h80002083) begin
      failures++; $display("[TB] FAIL min_imm_write: writes=%0d addr=%0d data=%h required 1/3/80002083", wrCount - base, bus.imem_addr, bus.imem_wdata); end
    checks++; if (bus.count !== 3'd4 || bus.full !== 1'b1 || bus.enc_ready !== 1'b0) begin
      failures++; $display("[TB] FAIL full_flag: count=%0d full=%b ready=%b required 4/1/0", bus.count, bus.full, bus.enc_ready); end
  endtask

  task automatic test_boundaries();
    int base;
    pulseClear();
    checks++; if (bus.count !== 3'd0 || bus.full !== 1'b0 || bus.err_count !== 8'd0) begin
      failures++; $display("[TB] FAIL clear_state: count=%0d full=%b errcnt=%0d required 0/0/0", bus.count, bus.full, bus.err_count); end
    base = wrCount;
    issue(2'b01, 5'd0, 5'd0, 5'd0, 3'd0, 32'd2047);
    repeat (3) @(negedge clk);
    issue(2'b11, 5'd0, 5'd0, 5'd0, 3'd0, 32'd4096);
    repeat (3) @(negedge clk);
    issue(2'b11, 5'd0, 5'd0, 5'd0, 3'd0, 32'd4094);
    repeat (3) @(negedge clk);
    issue(2'b11, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFFF000);
    repeat (3) @(negedge clk);
    issue(2'b11, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFFEFFE);
    repeat (3) @(negedge clk);
    checks++; if (wrCount - base !== 3 || bus.err_count !== 8'd2 || bus.count !== 3'd3) begin
      failures++; $display("[TB] FAIL bound_totals: writes=%0d errcnt=%0d count=%0d required 3/2/3", wrCount - base, bus.err_count, bus.count); end
    else begin
      checks++; if (wrData[base] !== 32'h7FF00013 || wrData[base+1] !== 32'h7E000FE3 || wrData[base+2] !== 32'h80000063) begin
        failures++; $display("[TB] FAIL bound_words: %h %h %h required 7ff00013 7e000fe3 80000063", wrData[base], wrData[base+1], wrData[base+2]); end
    end
  endtask

  task automatic test_back_to_back();
    int base;
    int k = 0;
    int accCyc[4];
    logic [31:0] expData;
    pulseClear();
    base = wrCount;
    bus.fmt = 2'b01; bus.rd = 5'd1; bus.rs1 = 5'd1; bus.rs2 = 5'd0; bus.funct3 = 3'd0;
    bus.imm = 32'd1; bus.enc_valid = 1'b1;
    for (int c = 0; c < 40 && k < 4; c++) begin
      if (bus.enc_ready === 1'b1) begin
        accCyc[k] = c;
        k++;
        @(posedge clk); #1;
        bus.imm = 32'(k + 1);
      end
      @(negedge clk);
    end
    checks++; if (k !== 4) begin
      failures++; $display("[TB] FAIL b2b_accepts: got %0d required 4", k); end
    else begin
      checks++; if (accCyc[1] - accCyc[0] !== 3 || accCyc[2] - accCyc[1] !== 3 || accCyc[3] - accCyc[2] !== 3) begin
        failures++; $display("[TB] FAIL b2b_spacing: %0d %0d %0d required 3 3 3", accCyc[1] - accCyc[0], accCyc[2] - accCyc[1], accCyc[3] - accCyc[2]); end
    end
    repeat (3) @(negedge clk);
    checks++; if (wrCount - base !== 4) begin
      failures++; $display("[TB] FAIL b2b_writes: got %0d required 4", wrCount - base); end
    else begin
      for (int i = 0; i < 4; i++) begin
        expData = 32'h00008093 | (32'(i + 1) << 20);
        checks++; if (wrAddr[base+i] !== 2'(i) || wrData[base+i] !== expData) begin
          failures++; $display("[TB] FAIL b2b_word%0d: addr=%0d data=%h required %0d/%h", i, wrAddr[base+i], wrData[base+i], i, expData); end
      end
    end
    checks++; if (bus.full !== 1'b1 || bus.enc_ready !== 1'b0 || bus.count !== 3'd4) begin
      failures++; $display("[TB] FAIL b2b_full: full=%b ready=%b count=%0d required 1/0/4", bus.full, bus.enc_ready, bus.count); end
    repeat (10) @(negedge clk);
    checks++; if (wrCount - base !== 4 || bus.count !== 3'd4) begin
      failures++; $display("[TB] FAIL full_holds: writes=%0d count=%0d required 4/4", wrCount - base, bus.count); end
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    checks++; if (bus.count !== 3'd0 || bus.full !== 1'b0 || bus.enc_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL full_clear: count=%0d full=%b ready=%b required 0/0/1", bus.count, bus.full, bus.enc_ready); end
    @(posedge clk); #1;
    bus.enc_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (wrCount - base !== 5 || bus.imem_addr !== 2'd0 || bus.imem_wdata !== 32'h00508093 || bus.count !== 3'd1) begin
      failures++; $display("[TB] FAIL post_clear_write: writes=%0d addr=%0d data=%h count=%0d required 5/0/00508093/1", wrCount - base, bus.imem_addr, bus.imem_wdata, bus.count); end
  endtask

  task automatic test_clear_enc();
    int base = wrCount;
    issue(2'b01, 5'd2, 5'd3, 5'd0, 3'd0, 32'd7);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (wrCount !== base || bus.count !== 3'd0 || bus.imem_we !== 1'b0 || bus.enc_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL clear_in_enc: writes=%0d count=%0d we=%b ready=%b required 0/0/0/1", wrCount - base, bus.count, bus.imem_we, bus.enc_ready); end
  endtask

  task automatic test_async_reset();
    issue(2'b00, 5'd0, 5'd0, 5'd0, 3'd0, 32'd3000);
    repeat (2) @(negedge clk);
    issue(2'b01, 5'd1, 5'd1, 5'd0, 3'd0, 32'd9);
    @(posedge clk); #2;
    checks++; if (bus.imem_we !== 1'b1 || bus.err_count !== 8'd1) begin
      failures++; $display("[TB] FAIL pre_reset_write: we=%b errcnt=%0d required 1/1", bus.imem_we, bus.err_count); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.imem_we !== 1'b0 || bus.imem_addr !== 2'd0 || bus.imem_wdata !== 32'd0) begin
      failures++; $display("[TB] FAIL async_reset_port: we=%b addr=%0d data=%h required 0/0/0", bus.imem_we, bus.imem_addr, bus.imem_wdata); end
    checks++; if (bus.count !== 3'd0 || bus.full !== 1'b0 || bus.err_pulse !== 1'b0 || bus.err_count !== 8'd0) begin
      failures++; $display("[TB] FAIL async_reset_status: count=%0d full=%b err=%b errcnt=%0d required all 0", bus.count, bus.full, bus.err_pulse, bus.err_count); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (bus.enc_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL async_reset_ready: enc_ready=%b required 1", bus.enc_ready); end
  endtask

  initial begin
    bus.enc_valid = 1'b0;
    bus.fmt = '0; bus.rd = '0; bus.rs1 = '0; bus.rs2 = '0; bus.funct3 = '0; bus.imm = '0;
    test_reset();
    test_i_alu();
    test_s_sb();
    test_errors();
    test_boundaries();
    test_back_to_back();
    test_clear_enc();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
